// File: rtl/ps2_key_assembler.sv
// ps2_key_assembler
//
// Receives raw PS/2 keyboard frames on the board pins and groups the bytes
// into complete key events. Prefix bytes (E0, F0) and the eight-byte E1
// pause sequence are collected into one event. Each event is published as
// a 65-bit toggle-flagged word in the hps_io ps2_key format. All logic runs
// on the rising edge of clk_sys.
//
// Ports:
//   clk_sys    in   1   system clock
//   RESET_N    in   1   asynchronous active-low reset
//   ps2_clk    in   1   raw PS/2 clock line (asynchronous)
//   ps2_data   in   1   raw PS/2 data line (asynchronous)
//   ps2_key    out  65  bit 64 toggles per event; 63:0 event bytes, newest in 7:0
//   rx_byte    out  8   last correctly received byte
//   rx_strobe  out  1   one-cycle pulse when rx_byte updates
//   frame_err  out  1   one-cycle pulse on start/parity/stop/timeout error
//
// Optional build macro: PS2_TYPEMATIC_FILTER_EN
//   When defined, a make event that repeats the last published make is
//   suppressed. The remembered make is cleared by any published break.

module ps2_key_assembler #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 60000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [64:0] ps2_key,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} bit_state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    bit_state_t    state;
    bit_state_t    next_state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          frame_ok;
    logic          frame_bad;

    logic [55:0]   evt_buf;
    logic [63:0]   new_buf;
    logic          in_pause;
    logic [2:0]    pause_cnt;
    logic          evt_done;
    logic          publish;

    // Two-flop synchronisers. Lines idle high, so reset them high to avoid
    // a spurious fall as reset releases.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock only follows the synchronised clock
    // after FILTER_LEN consecutive samples disagree with it. A high-to-low
    // change of the filtered clock produces a one-cycle fall pulse.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bit-level framing. Parity and stop are judged together on the stop
    // fall so a bad frame yields exactly one error pulse. A timeout only
    // applies inside a frame and loses to a coincident fall.
    always_comb begin
        next_state = state;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    if (!data_sync[1]) begin
                        next_state = S_DATA;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fall && bit_cnt == 3'd7) begin
                    next_state = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall) begin
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    next_state = S_IDLE;
                    if (data_sync[1] && (^shift ^ par_bit)) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (!fall && state != S_IDLE && tmo_cnt == TW'(TIMEOUT_CYC)) begin
            next_state = S_IDLE;
            frame_bad  = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            shift     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (fall || state == S_IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TW'(TIMEOUT_CYC)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (fall) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shift   <= {data_sync[1], shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_PARITY: par_bit <= data_sync[1];
                    default:  ;
                endcase
            end
            rx_strobe <= frame_ok;
            frame_err <= frame_bad;
            if (frame_ok) begin
                rx_byte <= shift;
            end
        end
    end

    // Event grouping. Only the newest seven bytes need storing because the
    // byte arriving with rx_strobe completes the 64-bit word; anything older
    // falls off the top silently.
    assign new_buf = {evt_buf, rx_byte};

    always_comb begin
        evt_done = 1'b0;
        if (rx_strobe) begin
            if (in_pause) begin
                evt_done = (pause_cnt == 3'd7);
            end else if (rx_byte != 8'hE1 && rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
                evt_done = 1'b1;
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [63:0] last_make;
    logic        is_make;

    assign is_make = (new_buf[15:8] != 8'hF0) && (new_buf[7:0] != 8'hF0);
    assign publish = evt_done && !(is_make && new_buf == last_make);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            last_make <= '0;
        end else if (publish) begin
            last_make <= is_make ? new_buf : 64'd0;
        end
    end
`else
    assign publish = evt_done;
`endif

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            evt_buf   <= '0;
            in_pause  <= 1'b0;
            pause_cnt <= '0;
            ps2_key   <= '0;
        end else if (frame_err) begin
            evt_buf   <= '0;
            in_pause  <= 1'b0;
            pause_cnt <= '0;
        end else if (rx_strobe) begin
            if (evt_done) begin
                evt_buf   <= '0;
                in_pause  <= 1'b0;
                pause_cnt <= '0;
            end else begin
                evt_buf <= new_buf[55:0];
                if (in_pause) begin
                    pause_cnt <= pause_cnt + 1'b1;
                end else if (rx_byte == 8'hE1) begin
                    in_pause  <= 1'b1;
                    pause_cnt <= 3'd1;
                end
            end
            if (publish) begin
                ps2_key <= {~ps2_key[64], new_buf};
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_assembler.sv
// Testbench for ps2_key_assembler: drives PS/2 frames bit by bit and keeps
// scoreboards of expected received bytes and published events. A monitor
// running on the falling edge of clk_sys pops and compares them.

module tb_ps2_key_assembler;

    localparam int HALF        = 20;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 60000;

    logic        clk_sys  = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [64:0] ps2_key;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic        frame_err;

    logic [64:0] exp_key_q[$];
    logic [7:0]  exp_byte_q[$];
    logic        exp_flag  = 1'b0;
    logic        prev_flag = 1'b0;
    logic [64:0] prev_key  = '0;
    int          exp_err   = 0;
    int          seen_err  = 0;
    int          checks    = 0;
    int          failures  = 0;

    always #5 clk_sys = ~clk_sys;

    ps2_key_assembler #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys   (clk_sys),
        .RESET_N   (RESET_N),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err)
    );

    task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Sends the first nbits bits of an 11-bit frame (start, 8 data LSB first,
    // odd parity, stop). bad_par inverts the parity bit.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            waitClk(HALF);
            ps2_clk = 1'b0;
            waitClk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        waitClk(HALF);
    endtask

    task automatic sendGood(input logic [7:0] b);
        exp_byte_q.push_back(b);
        applyStimulus(b, 1'b0, 11);
    endtask

    task automatic pushEvent(input logic [63:0] v);
        exp_flag = ~exp_flag;
        exp_key_q.push_back({exp_flag, v});
    endtask

    // Scoreboard monitor
    always @(negedge clk_sys) begin
        if (RESET_N) begin
            if (rx_strobe) begin
                if (exp_byte_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rx_strobe: got byte %h, expected no strobe", rx_byte);
                end else begin
                    checkOutput("rx_byte", 65'(rx_byte), 65'(exp_byte_q.pop_front()));
                end
            end
            if (ps2_key[64] !== prev_flag) begin
                if (exp_key_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_toggle: got %h, expected no event", ps2_key);
                end else begin
                    checkOutput("ps2_key_event", ps2_key, exp_key_q.pop_front());
                end
            end else if (ps2_key !== prev_key) begin
                checks++;
                failures++;
                $display("[TB] FAIL ps2_key_stable: got %h, expected %h", ps2_key, prev_key);
            end
            if (frame_err) seen_err++;
        end
        prev_flag = ps2_key[64];
        prev_key  = ps2_key;
    end

    initial begin
        RESET_N = 1'b0;
        waitClk(5);
        checkOutput("reset_ps2_key", ps2_key, 65'd0);
        checkOutput("reset_rx_byte", 65'(rx_byte), 65'd0);
        checkOutput("reset_rx_strobe", 65'(rx_strobe), 65'd0);
        checkOutput("reset_frame_err", 65'(frame_err), 65'd0);
        RESET_N = 1'b1;
        waitClk(5);

        // Single make code
        pushEvent(64'h1C);
        sendGood(8'h1C);
        waitClk(10);
        checkOutput("flag_after_1C", 65'(ps2_key[64]), 65'd1);

        // Extended break: one event after the third byte
        sendGood(8'hE0);
        sendGood(8'hF0);
        pushEvent(64'hE0F075);
        sendGood(8'h75);

        // Bad parity is dropped, then the same byte arrives correctly
        exp_err++;
        applyStimulus(8'h29, 1'b1, 11);
        waitClk(10);
        checkOutput("err_after_parity", 65'(seen_err), 65'(exp_err));
        pushEvent(64'h29);
        sendGood(8'h29);

        // Start bit of 1 in idle
        exp_err++;
        applyStimulus(8'hFF, 1'b0, 0);
        ps2_data = 1'b1;
        waitClk(HALF);
        ps2_clk = 1'b0;
        waitClk(HALF);
        ps2_clk = 1'b1;
        waitClk(HALF);
        checkOutput("err_after_start", 65'(seen_err), 65'(exp_err));

        // Abandoned frame times out, then a valid frame still works
        exp_err++;
        applyStimulus(8'h5A, 1'b0, 6);
        waitClk(TIMEOUT_CYC + 10);
        checkOutput("err_after_timeout", 65'(seen_err), 65'(exp_err));
        pushEvent(64'h14);
        sendGood(8'h14);

        // Pause sequence: a single event after eight bytes
        sendGood(8'hE1);
        sendGood(8'h14);
        sendGood(8'h77);
        sendGood(8'hE1);
        sendGood(8'hF0);
        sendGood(8'h14);
        sendGood(8'hF0);
        pushEvent(64'hE11477E1F014F077);
        sendGood(8'h77);

        // Typematic repeat of 1C around a break
        pushEvent(64'h1C);
        sendGood(8'h1C);
`ifndef PS2_TYPEMATIC_FILTER_EN
        pushEvent(64'h1C);
`endif
        sendGood(8'h1C);
        sendGood(8'hF0);
        pushEvent(64'hF01C);
        sendGood(8'h1C);
        pushEvent(64'h1C);
        sendGood(8'h1C);

        waitClk(50);
        checkOutput("events_outstanding", 65'(exp_key_q.size()), 65'd0);
        checkOutput("bytes_outstanding", 65'(exp_byte_q.size()), 65'd0);
        checkOutput("err_total", 65'(seen_err), 65'(exp_err));
        checkOutput("final_flag", 65'(ps2_key[64]), 65'(exp_flag));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
